sram_arb_ctrl: RTL
==================

SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 7, giving the word address width (depth 1<<ADDR_WIDTH = 128).
REQ-003 Port clk0  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst0  input  1  synchronous, active-high reset.
REQ-005 Ports mN_valid  input  1  request present, for N = 0 and N = 1.
REQ-006 Ports mN_ready  output  1  request accepted this cycle.
REQ-007 Ports mN_we  input  1  1 = write, 0 = read.
REQ-008 Ports mN_addr  input  ADDR_WIDTH  word address.
REQ-009 Ports mN_wdata  input  DATA_WIDTH  write data.
REQ-010 Ports mN_rvalid  output  1  one-cycle read-response strobe.
REQ-011 Ports mN_rdata  output  DATA_WIDTH  read data, held until the next response to that port.
REQ-012 Port init_done  output  1  scrub complete; arbitration active.
REQ-013 Ports sram_csb0, sram_web0  output  1 each  active-low chip select and write enable to the 1rw macro.
REQ-014 Port sram_addr0  output  ADDR_WIDTH  address to the macro.
REQ-015 Port sram_din0  output  DATA_WIDTH  write data to the macro.
REQ-016 Port sram_dout0  input  DATA_WIDTH  macro read data, valid after the falling edge following macro capture.

Function
REQ-017 The FSM SHALL have two states: INIT (scrub) and RUN.
REQ-018 In INIT, an address counter SHALL walk 0..127, issuing one write of all-zeros per cycle; mN_ready SHALL be 0.
REQ-019 INIT SHALL go to RUN on the edge that issues address 127; init_done SHALL rise on that same edge and stay 1 until reset.
REQ-020 In RUN, mN_ready SHALL be combinational: mN_valid AND (port N wins arbitration); at most one ready per cycle.
REQ-021 Arbitration SHALL be round-robin: with both valid, the port not granted most recently wins; after reset, port 0 has priority.
REQ-022 With a single valid port, that port SHALL be granted in the same cycle, with no idle cycle.
REQ-023 An accepted request (valid & ready at edge E0) SHALL drive sram_csb0=0, sram_web0=~we, addr and wdata from registers during E0..E1.
REQ-024 With no accepted request, the block SHALL drive sram_csb0=1 in the following cycle; sram_web0 SHALL be 1 and addr/din SHALL hold their previous values.
REQ-025 A read accepted at E0 SHALL register sram_dout0 at E2 into the requester's mN_rdata, with mN_rvalid=1 for the cycle E2..E3 (fixed 2-cycle latency).
REQ-026 Read responses SHALL be routed by a 2-stage port tag pipeline; back-to-back reads, including alternating ports, SHALL produce back-to-back responses in acceptance order.
REQ-027 Writes SHALL produce no response.
REQ-028 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-029 Throughput SHALL be one access per cycle sustained.

Reset
REQ-030 While rst0=1, the block SHALL drive: sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0, mN_ready=0, mN_rvalid=0, mN_rdata=0, init_done=0; state=INIT; counter=0; round-robin pointer at port 0.
REQ-031 Reset mid-operation SHALL discard in-flight read responses (no rvalid) and SHALL re-scrub the whole memory after release.

Structure
REQ-032 A shared package SHALL hold DATA_WIDTH/ADDR_WIDTH defaults, the FSM state enum {INIT, RUN}, and the read latency constant (2).
REQ-033 The two-requester round-robin grant logic SHALL be one sub-module, rr_arb2.

Verification
REQ-034 Release reset -> exactly 128 writes, addresses 0..127 with din=0; init_done high on cycle 128; ready low until then.
REQ-035 After init, m0 writes 0xDEADBEEF @0x05, then the next cycle m0 reads @0x05 -> m0_rvalid 2 cycles after read acceptance, m0_rdata=0xDEADBEEF.
REQ-036 m0 and m1 both hold valid reads (@0x01, @0x02, preloaded 0x11, 0x22) for 4 cycles -> grants alternate m0,m1,m0,m1, and responses return in that order with correct data.
REQ-037 Read of any unwritten address after init -> rdata=0x00000000.
REQ-038 Assert rst0 for 1 cycle with 2 reads in flight -> no rvalid; a new scrub of 128 cycles runs; previously written data reads back 0.
REQ-039 Only m1 valid, continuous reads over 10 cycles -> m1_ready high every cycle, 10 consecutive rvalid pulses.

Source files
------------

// File: rtl/sram_arb_ctrl_pkg.sv
// Shared constants and types for the two-port arbitrated SRAM controller.
package sram_arb_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 7;
  localparam int READ_LATENCY   = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Identifies which requester a read in flight belongs to.
  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; port 0 has priority after reset.
module rr_arb2 (
  input  logic       clk0,
  input  logic       rst0,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Set when port 1 should win the next contested cycle.
  logic prio1_q;

  assign gnt[0] = req[0] & (~req[1] | ~prio1_q);
  assign gnt[1] = req[1] & (~req[0] |  prio1_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      prio1_q <= 1'b0;
    end else if (|gnt) begin
      prio1_q <= gnt[0];
    end
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Scrubs a 1rw SRAM macro after reset, then arbitrates two requesters onto it
// with a fixed two-cycle read latency and tag-routed responses.
module sram_arb_ctrl
  import sram_arb_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk0,
  input  logic                  rst0,

  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic                  init_done,

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  run_active;
  logic [1:0]            req, gnt;
  logic                  accept;
  logic                  we_sel;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;
  rd_tag_t               tag_q [READ_LATENCY];
  rd_tag_t               tag_out;

  // Reset gates the grant directly so ready is low from the first reset cycle.
  assign run_active = (state_q == RUN) & ~rst0;
  assign req        = {m1_valid, m0_valid} & {2{run_active}};

  rr_arb2 u_arb (
    .clk0 (clk0),
    .rst0 (rst0),
    .req  (req),
    .gnt  (gnt)
  );

  assign m0_ready = gnt[0];
  assign m1_ready = gnt[1];
  assign accept   = |gnt;
  assign tag_out  = tag_q[READ_LATENCY-1];

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    we_sel    = m0_we;
    addr_sel  = m0_addr;
    wdata_sel = m0_wdata;
    if (gnt[1]) begin
      we_sel    = m1_we;
      addr_sel  = m1_addr;
      wdata_sel = m1_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && cnt_q == '1) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Macro command, scrub counter and init flag.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      cnt_q      <= '0;
      init_done  <= 1'b0;
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
    end else begin
      init_done <= (state_d == RUN);
      if (state_q == INIT) begin
        sram_csb0  <= 1'b0;
        sram_web0  <= 1'b0;
        sram_addr0 <= cnt_q;
        sram_din0  <= '0;
        cnt_q      <= cnt_q + ADDR_WIDTH'(1);
      end else if (accept) begin
        sram_csb0  <= 1'b0;
        sram_web0  <= ~we_sel;
        sram_addr0 <= addr_sel;
        sram_din0  <= wdata_sel;
      end else begin
        sram_csb0  <= 1'b1;
        sram_web0  <= 1'b1;
      end
    end
  end

  // Read tags follow the macro: issue, macro capture, then response register.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      tag_q[0] <= '{valid: accept & ~we_sel, port: gnt[1]};
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      m0_rvalid <= tag_out.valid & ~tag_out.port;
      m1_rvalid <= tag_out.valid &  tag_out.port;
      if (tag_out.valid && !tag_out.port) m0_rdata <= sram_dout0;
      if (tag_out.valid &&  tag_out.port) m1_rdata <= sram_dout0;
    end
  end

endmodule
